// File: rtl/stereo_pkg.sv
// Shared definitions for the slave-camera parameter apply stage: bundle layout,
// FSM encoding and reset constants.
package stereo_pkg;

  localparam int BUNDLE_W = 65;
  localparam int ZOOM_LSB = 0;
  localparam int INT_LSB  = 32;
  localparam int GAIN_BIT = 64;

  localparam logic [31:0] INT_TIME_DEFAULT_C = 32'd1000;

  typedef enum logic {
    ST_TRACK   = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

endpackage

// File: rtl/stereo_param_stability_filter.sv
// Periodic sampler that accepts a bundle once it has been seen unchanged on
// STABLE_COUNT+1 consecutive sample ticks.
module stereo_param_stability_filter
  import stereo_pkg::*;
#(
  parameter int SAMPLE_DIV   = 64,
  parameter int STABLE_COUNT = 4,
  parameter logic [BUNDLE_W-1:0] RESET_BUNDLE = '0
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                enable,
  input  logic [BUNDLE_W-1:0] sample,
  output logic                accept,
  output logic [BUNDLE_W-1:0] accept_bundle
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [3:0]  STAB_MAX = 4'(STABLE_COUNT);

  logic [15:0]         div_cnt;
  logic [3:0]          stab_cnt;
  logic [BUNDLE_W-1:0] prev_q;
  logic                tick;
  logic                same;

  assign tick = (div_cnt == DIV_LAST);
  assign same = (sample == prev_q);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      div_cnt  <= '0;
      stab_cnt <= '0;
      prev_q   <= RESET_BUNDLE;
    end else if (!enable) begin
      div_cnt  <= '0;
      stab_cnt <= '0;
    end else begin
      div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
      if (tick) begin
        prev_q <= sample;
        if (!same)
          stab_cnt <= '0;
        else if (stab_cnt != STAB_MAX)
          stab_cnt <= stab_cnt + 4'd1;
      end
    end
  end

  // Saturation at STAB_MAX makes this fire exactly once per stable run.
  assign accept        = enable && tick && same && (stab_cnt == STAB_MAX - 4'd1);
  assign accept_bundle = prev_q;

endmodule

// File: rtl/stereo_param_apply.sv
// Slave-camera stage: synchronises link-receiver parameters, filters them for
// stability and commits accepted bundles to the sensor at frame start.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_TRACK   | outputs current, waiting for a new stable bundle
//   ST_PENDING | new bundle held in pend, applied on next VSYNC rise
module stereo_param_apply
  import stereo_pkg::*;
#(
  parameter int          SAMPLE_DIV       = 64,
  parameter int          STABLE_COUNT     = 4,
  parameter int          TIMEOUT_FRAMES   = 8,
  parameter logic [31:0] INT_TIME_DEFAULT = INT_TIME_DEFAULT_C
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        ENABLE,
  input  logic        GAIN_IN,
  input  logic [31:0] INT_TIME_IN,
  input  logic [31:0] ZOOM_IN,
  input  logic        VSYNC,
  input  logic [31:0] INT_TIME_MAX,
  output logic        GAIN_OUT,
  output logic [31:0] INT_TIME_OUT,
  output logic [31:0] ZOOM_OUT,
  output logic        PARAM_UPDATE,
  output logic        LINK_ERR
);

  localparam logic [BUNDLE_W-1:0] RESET_BUNDLE = {1'b0, INT_TIME_DEFAULT, 32'd0};
  localparam logic [7:0]          TIMEOUT_C    = 8'(TIMEOUT_FRAMES);

  logic [BUNDLE_W-1:0] bsync1_q;
  logic [BUNDLE_W-1:0] sample_q;
  logic [2:0]          vs_q;
  logic                vsync_rise;

  logic                accept;
  logic [BUNDLE_W-1:0] accept_bundle;

  state_t              state_q;
  state_t              state_d;
  logic [BUNDLE_W-1:0] pend_q;
  logic [BUNDLE_W-1:0] applied_q;
  logic [7:0]          frame_cnt_q;
  logic                apply;
  logic                pend_load;
  logic                differs_applied;
  logic                differs_pend;
  logic [31:0]         pend_int;
  logic [31:0]         int_clamped;

  // Bundle words may be torn while crossing; the stability filter rejects them.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bsync1_q <= RESET_BUNDLE;
      sample_q <= RESET_BUNDLE;
      vs_q     <= '0;
    end else begin
      bsync1_q <= {GAIN_IN, INT_TIME_IN, ZOOM_IN};
      sample_q <= bsync1_q;
      vs_q     <= {vs_q[1:0], VSYNC};
    end
  end

  assign vsync_rise = vs_q[1] & ~vs_q[2];

  stereo_param_stability_filter #(
    .SAMPLE_DIV   (SAMPLE_DIV),
    .STABLE_COUNT (STABLE_COUNT),
    .RESET_BUNDLE (RESET_BUNDLE)
  ) u_filter (
    .CLK           (CLK),
    .nRESET        (nRESET),
    .enable        (ENABLE),
    .sample        (sample_q),
    .accept        (accept),
    .accept_bundle (accept_bundle)
  );

  assign differs_applied = (accept_bundle != applied_q);
  assign differs_pend    = (accept_bundle != pend_q);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state_q <= ST_TRACK;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!ENABLE) begin
      state_d = ST_TRACK;
    end else begin
      case (state_q)
        ST_TRACK: begin
          if (accept && differs_applied) state_d = ST_PENDING;
        end
        ST_PENDING: begin
          // On a same-cycle apply, pend becomes the applied value for the compare.
          if (vsync_rise)
            state_d = (accept && differs_pend) ? ST_PENDING : ST_TRACK;
          else if (accept && !differs_applied)
            state_d = ST_TRACK;
        end
        default: state_d = ST_TRACK;
      endcase
    end
  end

  always_comb begin
    apply     = ENABLE && (state_q == ST_PENDING) && vsync_rise;
    pend_load = 1'b0;
    if (ENABLE && accept) begin
      if (state_q == ST_PENDING && vsync_rise) pend_load = differs_pend;
      else                                     pend_load = differs_applied;
    end
  end

  assign pend_int    = pend_q[INT_LSB +: 32];
  assign int_clamped = (pend_int > INT_TIME_MAX) ? INT_TIME_MAX : pend_int;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      pend_q       <= RESET_BUNDLE;
      applied_q    <= RESET_BUNDLE;
      GAIN_OUT     <= 1'b0;
      INT_TIME_OUT <= INT_TIME_DEFAULT;
      ZOOM_OUT     <= '0;
      PARAM_UPDATE <= 1'b0;
    end else begin
      PARAM_UPDATE <= apply;
      if (apply) begin
        applied_q    <= pend_q;
        GAIN_OUT     <= pend_q[GAIN_BIT];
        INT_TIME_OUT <= int_clamped;
        ZOOM_OUT     <= pend_q[ZOOM_LSB +: 32];
      end
      if (pend_load) pend_q <= accept_bundle;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      frame_cnt_q <= '0;
      LINK_ERR    <= 1'b0;
    end else if (!ENABLE) begin
      frame_cnt_q <= '0;
      LINK_ERR    <= 1'b0;
    end else begin
      if (accept)
        frame_cnt_q <= '0;
      else if (vsync_rise && frame_cnt_q != TIMEOUT_C)
        frame_cnt_q <= frame_cnt_q + 8'd1;
      LINK_ERR <= (frame_cnt_q == TIMEOUT_C);
    end
  end

endmodule

// File: tb/tb_stereo_param_apply.sv
// Scoreboard bench for stereo_param_apply: expected updates are queued by the
// stimulus and matched by a monitor against every PARAM_UPDATE pulse.
module tb_stereo_param_apply;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        ENABLE;
  logic        GAIN_IN;
  logic [31:0] INT_TIME_IN;
  logic [31:0] ZOOM_IN;
  logic        VSYNC;
  logic [31:0] INT_TIME_MAX;
  logic        GAIN_OUT;
  logic [31:0] INT_TIME_OUT;
  logic [31:0] ZOOM_OUT;
  logic        PARAM_UPDATE;
  logic        LINK_ERR;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        g;
    logic [31:0] it;
    logic [31:0] zm;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  stereo_param_apply #(
    .SAMPLE_DIV       (8),
    .STABLE_COUNT     (4),
    .TIMEOUT_FRAMES   (3),
    .INT_TIME_DEFAULT (32'd1000)
  ) dut (
    .CLK          (CLK),
    .nRESET       (nRESET),
    .ENABLE       (ENABLE),
    .GAIN_IN      (GAIN_IN),
    .INT_TIME_IN  (INT_TIME_IN),
    .ZOOM_IN      (ZOOM_IN),
    .VSYNC        (VSYNC),
    .INT_TIME_MAX (INT_TIME_MAX),
    .GAIN_OUT     (GAIN_OUT),
    .INT_TIME_OUT (INT_TIME_OUT),
    .ZOOM_OUT     (ZOOM_OUT),
    .PARAM_UPDATE (PARAM_UPDATE),
    .LINK_ERR     (LINK_ERR)
  );

  always #5 CLK = ~CLK;

  // Edges since reset release; the DUT sample ticks land on multiples of 8.
  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (nRESET && PARAM_UPDATE) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_update actual=g%0d i%0d z%0d cyc%0d required=no_update",
                 GAIN_OUT, INT_TIME_OUT, ZOOM_OUT, cyc);
      end else begin
        e = exp_q.pop_front();
        if (GAIN_OUT !== e.g || INT_TIME_OUT !== e.it || ZOOM_OUT !== e.zm || cyc != e.at) begin
          failures++;
          $display("FAIL update actual=g%0d i%0d z%0d cyc%0d required=g%0d i%0d z%0d cyc%0d",
                   GAIN_OUT, INT_TIME_OUT, ZOOM_OUT, cyc, e.g, e.it, e.zm, e.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic align4();
    @(negedge CLK);
    while (cyc % 8 != 4) @(negedge CLK);
  endtask

  task automatic set_in(input logic g, input logic [31:0] it, input logic [31:0] zm);
    GAIN_IN     = g;
    INT_TIME_IN = it;
    ZOOM_IN     = zm;
  endtask

  // Raises VSYNC at the current negedge; the update, if any, shows 3 edges later.
  task automatic vsync_pulse(input bit expect_upd, input logic g,
                             input logic [31:0] it, input logic [31:0] zm);
    exp_t x;
    if (expect_upd) begin
      x.g = g; x.it = it; x.zm = zm; x.at = cyc + 3;
      exp_q.push_back(x);
    end
    VSYNC = 1'b1;
    wait_neg(6);
    VSYNC = 1'b0;
    wait_neg(6);
  endtask

  initial begin
    int c0;
    nRESET       = 1'b0;
    ENABLE       = 1'b1;
    VSYNC        = 1'b0;
    INT_TIME_MAX = 32'd5000;
    set_in(1'b1, 32'd2000, 32'd7);
    wait_neg(3);
    chk("reset_gain", {31'd0, GAIN_OUT}, 32'd0);
    chk("reset_int", INT_TIME_OUT, 32'd1000);
    chk("reset_zoom", ZOOM_OUT, 32'd0);
    chk("reset_update", {31'd0, PARAM_UPDATE}, 32'd0);
    chk("reset_link_err", {31'd0, LINK_ERR}, 32'd0);
    nRESET = 1'b1;

    // 1: first stable bundle applied at frame start, nothing on the next frame
    wait_cyc(60);
    vsync_pulse(1'b1, 1'b1, 32'd2000, 32'd7);
    wait_neg(20);
    vsync_pulse(1'b0, 1'b0, 32'd0, 32'd0);

    // 2: toggling word never accepted, timeout raised, then recovery
    align4();
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          INT_TIME_IN = (i % 2 == 0) ? 32'd2001 : 32'd2000;
          wait_neg(8);
        end
      end
      begin
        repeat (3) begin
          wait_neg(50);
          vsync_pulse(1'b0, 1'b0, 32'd0, 32'd0);
        end
      end
    join
    chk("toggle_link_err", {31'd0, LINK_ERR}, 32'd1);
    chk("toggle_int_held", INT_TIME_OUT, 32'd2000);
    chk("toggle_zoom_held", ZOOM_OUT, 32'd7);
    wait_neg(40);
    chk("recover_link_err", {31'd0, LINK_ERR}, 32'd0);
    vsync_pulse(1'b1, 1'b1, 32'd2001, 32'd7);

    // 3: integration time clamped to INT_TIME_MAX
    align4();
    set_in(1'b0, 32'd9000, 32'd3);
    wait_neg(48);
    vsync_pulse(1'b1, 1'b0, 32'd5000, 32'd3);

    // 4: latest accepted bundle wins
    align4();
    set_in(1'b1, 32'd100, 32'd1);
    wait_neg(48);
    set_in(1'b1, 32'd200, 32'd2);
    wait_neg(48);
    vsync_pulse(1'b1, 1'b1, 32'd200, 32'd2);

    // 5: accept of C lands on the same edge as the VSYNC rise applying A
    align4();
    set_in(1'b1, 32'd100, 32'd1);
    wait_neg(48);
    c0 = cyc;
    set_in(1'b0, 32'd300, 32'd5);
    wait_cyc(c0 + 33);
    vsync_pulse(1'b1, 1'b1, 32'd100, 32'd1);
    wait_neg(20);
    vsync_pulse(1'b1, 1'b0, 32'd300, 32'd5);

    // 6: disable drops the pending bundle; reset is asynchronous
    align4();
    set_in(1'b1, 32'd400, 32'd6);
    wait_neg(48);
    ENABLE = 1'b0;
    wait_neg(2);
    vsync_pulse(1'b0, 1'b0, 32'd0, 32'd0);
    chk("disabled_gain", {31'd0, GAIN_OUT}, 32'd0);
    chk("disabled_int", INT_TIME_OUT, 32'd300);
    chk("disabled_zoom", ZOOM_OUT, 32'd5);
    chk("disabled_link_err", {31'd0, LINK_ERR}, 32'd0);
    ENABLE = 1'b1;
    wait_neg(20);
    nRESET = 1'b0;
    #1;
    chk("async_reset_gain", {31'd0, GAIN_OUT}, 32'd0);
    chk("async_reset_int", INT_TIME_OUT, 32'd1000);
    chk("async_reset_zoom", ZOOM_OUT, 32'd0);
    @(negedge CLK);
    nRESET = 1'b1;
    wait_cyc(5);
    vsync_pulse(1'b0, 1'b0, 32'd0, 32'd0);
    wait_neg(4);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_update actual=%0d_outstanding required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stereo_param_apply.md
Name: stereo_param_apply

Overview:
- Slave-camera stage directly downstream of the stereo control link receiver.
- Consumes the gain, integration-time and zoom words recovered from the master (GAIN_FROM_MASTER, INT_TIME_FROM_MASTER, ZOOM_FROM_MASTER). These words are produced in the serial-clock domain.
- Synchronises them into CLK and filters out torn or transient words with a consecutive-sample stability check.
- Commits accepted values to the sensor-control outputs only at a frame boundary (VSYNC rise), so parameters never change mid-frame.

Parameters:
- SAMPLE_DIV, 64: CLK cycles between stability samples (range 2..65535).
- STABLE_COUNT, 4: consecutive equal samples, after the first, needed to accept a bundle (range 1..15).
- TIMEOUT_FRAMES, 8: frames without any accepted bundle before LINK_ERR asserts (range 1..255).
- INT_TIME_DEFAULT, 32'd1000: INT_TIME_OUT reset value.

Ports:
- CLK  in  1  system clock.
- nRESET  in  1  asynchronous active-low reset.
- ENABLE  in  1  1 = slave camera mode, block active.
- GAIN_IN  in  1  gain from link receiver; asynchronous.
- INT_TIME_IN  in  32  integration time from link receiver; asynchronous.
- ZOOM_IN  in  32  zoom from link receiver; asynchronous.
- VSYNC  in  1  sensor frame sync; asynchronous; rising edge = frame start.
- INT_TIME_MAX  in  32  static upper clamp for integration time.
- GAIN_OUT  out  1  applied gain.
- INT_TIME_OUT  out  32  applied integration time.
- ZOOM_OUT  out  32  applied zoom.
- PARAM_UPDATE  out  1  one-cycle pulse when outputs change.
- LINK_ERR  out  1  no stable bundle for TIMEOUT_FRAMES frames.

Behaviour:
- Clock and reset: one clock, CLK. nRESET is asynchronous and active-low.
- Reset values:
  - GAIN_OUT = 0, INT_TIME_OUT = INT_TIME_DEFAULT, ZOOM_OUT = 0.
  - PARAM_UPDATE = 0, LINK_ERR = 0.
  - State = TRACK; all counters 0.
  - Sample and pending registers = the reset output values.
- Synchronisation:
  - The 65-bit bundle {GAIN, INT_TIME, ZOOM} passes through 2 flops.
  - VSYNC passes through 2 flops plus an edge flop; a rise is detected 3 CLK after VSYNC goes high.
- Sample tick:
  - A divider counts 0..SAMPLE_DIV-1; tick when count = SAMPLE_DIV-1, then wrap to 0.
- Stability check, on each tick:
  - If sample == prev: stab_cnt increments, saturating at STABLE_COUNT. Otherwise stab_cnt = 0.
  - prev <= sample.
  - Accept event fires when stab_cnt goes from STABLE_COUNT-1 to STABLE_COUNT, i.e. the same bundle was seen on STABLE_COUNT+1 consecutive ticks.
  - Fires once per stable run.
- FSM (TRACK, PENDING):
  - TRACK: an accept whose bundle differs from the applied bundle loads pend <= bundle and moves to PENDING. An accept equal to the applied bundle only feeds the timeout logic.
  - PENDING, accept of a different non-applied bundle: pend is overwritten (latest wins).
  - PENDING, accept equal to the applied bundle: pend is dropped and the FSM returns to TRACK.
  - PENDING, VSYNC rise: outputs <= pend and PARAM_UPDATE = 1 on the same edge; FSM returns to TRACK. INT_TIME_OUT = min(pend_int, INT_TIME_MAX), unsigned compare.
- Same-cycle accept and VSYNC rise in PENDING:
  - The outputs take the old pend.
  - The new bundle is then evaluated against the just-applied value: if different it loads pend and the FSM stays PENDING; if equal the FSM goes to TRACK.
- VSYNC rise in TRACK: no output change, no pulse.
- PARAM_UPDATE pulses even when the clamped value equals the current output, provided the bundle differed.
- LINK_ERR:
  - frame_cnt increments on each VSYNC rise, saturating at TIMEOUT_FRAMES, and clears on any accept event.
  - LINK_ERR = (frame_cnt == TIMEOUT_FRAMES), registered. It clears on the cycle after the next accept.
- ENABLE = 0:
  - Outputs hold their values; PARAM_UPDATE = 0; LINK_ERR = 0.
  - FSM goes to TRACK; divider, stab_cnt and frame_cnt are cleared; synchronisers keep running.
- Reset asserted mid-operation: all state returns to the reset values immediately; a pending bundle is discarded.

Decomposition:
- Package stereo_pkg holds:
  - bundle width 65 and field offsets (ZOOM [31:0], INT_TIME [63:32], GAIN [64]);
  - FSM state encoding;
  - the INT_TIME_DEFAULT constant.
- One sub-module: stereo_param_stability_filter, containing the divider, prev/sample registers, stab_cnt and the accept-event output. The FSM, clamp, VSYNC sync and timeout stay in the top level.

Test Plan (SAMPLE_DIV = 8, STABLE_COUNT = 4, TIMEOUT_FRAMES = 3, INT_TIME_MAX = 5000):
1. Reset release, inputs held at {1, 2000, 7}, VSYNC rise after 60 CLK -> outputs {1, 2000, 7}, one PARAM_UPDATE pulse exactly 3 CLK after VSYNC rise; no pulse on the next VSYNC.
2. INT_TIME_IN toggles 2000/2001 every 8 CLK for 200 CLK, with 3 VSYNC rises -> no accept, outputs unchanged, LINK_ERR = 1 after the 3rd rise; then hold 2001 -> LINK_ERR clears after acceptance, 2001 applied at the next VSYNC.
3. Inputs {0, 9000, 3} stable, VSYNC rise -> INT_TIME_OUT = 5000, ZOOM_OUT = 3, PARAM_UPDATE = 1.
4. Accept A = {1, 100, 1}, then before VSYNC accept B = {1, 200, 2} -> VSYNC applies B only, single pulse.
5. Accept event aligned to the same cycle as the VSYNC edge detect while PENDING with A -> outputs = A, FSM stays PENDING with the new bundle, applied at the following VSYNC.
6. ENABLE = 0 while PENDING, VSYNC rise -> no change, no pulse; nRESET pulse mid-run -> GAIN 0, INT_TIME 1000, ZOOM 0 asynchronously.
